// File: rtl/mcs4_pad_bridge_pkg.sv
// Shared definitions for the MCS-4 pad bridge.
//   phase_e       : bus phase index, PH_A1 (0) .. PH_X3 (7)
//   drive_state_t : data-pad drive FSM state codes
//   *_IDLE        : reset levels of pins and synchronised inputs
package mcs4_pad_bridge_pkg;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } drive_state_t;

    // Active-low control pins idle high; the data bus idles pulled up.
    localparam logic CTRL_N_IDLE   = 1'b1;
    localparam logic DATA_IDLE_BIT = 1'b1;
    localparam logic TEST_IDLE     = 1'b0;

    // Phase advance; PH_X3 wraps to PH_A1 through the 3-bit overflow.
    function automatic phase_e phase_next(input phase_e ph);
        return phase_e'(ph + 3'd1);
    endfunction

endpackage

// File: rtl/mcs4_pad_bridge_if.sv
// Core-side bus of the pad bridge.
//   master : the CPU core (drives sync/data/cm, receives data_i/test)
//   slave  : the pad bridge
interface mcs4_pad_bridge_if #(
    parameter int DATA_W     = 4,
    parameter int NUM_CM_RAM = 4
) ();
    logic                  core_sync_n;
    logic [DATA_W-1:0]     core_data_o;
    logic                  core_data_oe;
    logic [DATA_W-1:0]     core_data_i;
    logic                  core_cm_rom_n;
    logic [NUM_CM_RAM-1:0] core_cm_ram_n;
    logic                  core_test;

    modport master (
        output core_sync_n, core_data_o, core_data_oe, core_cm_rom_n, core_cm_ram_n,
        input  core_data_i, core_test
    );

    modport slave (
        input  core_sync_n, core_data_o, core_data_oe, core_cm_rom_n, core_cm_ram_n,
        output core_data_i, core_test
    );
endinterface

// File: rtl/mcs4_pad_bridge_sync_ff.sv
// Flop chain with asynchronous reset to a parameterised value. Used as
// the pad-input synchroniser and as the matching delay line for the
// contention check.
//   clk, rst_n : clock, async active-low reset
//   i_d        : chain input
//   o_q        : chain output, STAGES cycles after i_d
module mcs4_pad_bridge_sync_ff #(
    parameter int           W       = 1,
    parameter int           STAGES  = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_chain [STAGES];

    // NOTE: every stage is reset, not just the last one, so the output
    // never shows a stale pre-reset value while the chain refills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) r_chain[s] <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments make each stage take the
            // previous stage's old value, giving a true shift register.
            r_chain[0] <= i_d;
            for (int s = 1; s < STAGES; s++) r_chain[s] <= r_chain[s-1];
        end
    end

    assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/mcs4_pad_bridge.sv
// Pad-side bridge between the MCS-4 CPU core and the chip pins.
// Registers core control outputs, synchronises pad inputs, tracks the
// 8-phase bus cycle from SYNC_N and drives the data pads in open-drain or
// push-pull mode behind a direction-turnaround guard. Sticky flags report
// misplaced SYNC pulses and driven-data/readback contention.
//   clk, rst_n                 : clock, async active-low reset
//   core                       : core-side bus (slave modport)
//   pad_data_in/out/oe         : data pins (oe per bit, 1 = drive)
//   pad_test                   : TEST pin
//   pad_sync_n, pad_cm_*       : registered control pins
//   phase, phase_valid         : bus phase (0 = A1 .. 7 = X3), locked flag
//   sync_err, contention       : sticky error flags, cleared by err_clr
module mcs4_pad_bridge
    import mcs4_pad_bridge_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int NUM_CM_RAM  = 4,
    parameter bit OPEN_DRAIN  = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mcs4_pad_bridge_if.slave      core,
    input  logic [DATA_W-1:0]     pad_data_in,
    output logic [DATA_W-1:0]     pad_data_out,
    output logic [DATA_W-1:0]     pad_data_oe,
    input  logic                  pad_test,
    output logic                  pad_sync_n,
    output logic                  pad_cm_rom_n,
    output logic [NUM_CM_RAM-1:0] pad_cm_ram_n,
    output logic [2:0]            phase,
    output logic                  phase_valid,
    output logic                  sync_err,
    output logic                  contention,
    input  logic                  err_clr
);
    if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("mcs4_pad_bridge: SYNC_STAGES must be 1..3");
    end
    if (TURNAROUND < 0 || TURNAROUND > 3) begin : g_bad_turnaround
        $error("mcs4_pad_bridge: TURNAROUND must be 0..3");
    end

    localparam logic [1:0] GUARD_LOAD = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

    phase_e                r_phase;
    logic                  r_phase_valid;
    logic                  r_sync_err;
    logic                  r_contention;
    drive_state_t          r_state;
    drive_state_t          w_state_nx;
    logic [1:0]            r_guard;
    logic [1:0]            w_guard_nx;
    logic                  r_oe_q;
    logic [DATA_W-1:0]     r_data_q;
    logic                  r_oe_dly_prev;
    logic                  w_oe_dly;
    logic [DATA_W-1:0]     w_data_dly;
    logic                  w_sync_seen;
    logic                  w_sync_err_set;
    logic                  w_contention_set;

    // Control pins and phase tracking
    assign w_sync_seen    = ~core.core_sync_n;
    assign w_sync_err_set = w_sync_seen & r_phase_valid & (r_phase != PH_X3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_sync_n    <= CTRL_N_IDLE;
            pad_cm_rom_n  <= CTRL_N_IDLE;
            pad_cm_ram_n  <= {NUM_CM_RAM{CTRL_N_IDLE}};
            r_phase       <= PH_A1;
            r_phase_valid <= 1'b0;
        end else begin
            pad_sync_n   <= core.core_sync_n;
            pad_cm_rom_n <= core.core_cm_rom_n;
            pad_cm_ram_n <= core.core_cm_ram_n;
            // A SYNC always realigns, even a misplaced one.
            if (w_sync_seen) begin
                r_phase       <= PH_A1;
                r_phase_valid <= 1'b1;
            end else if (r_phase_valid) begin
                r_phase <= phase_next(r_phase);
            end
        end
    end

    // Drive FSM with turnaround guard
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        w_state_nx = r_state;
        w_guard_nx = r_guard;
        unique case (r_state)
            ST_IDLE: begin
                if (core.core_data_oe) begin
                    if (TURNAROUND == 0) begin
                        w_state_nx = ST_DRIVE;
                    end else begin
                        w_state_nx = ST_GUARD;
                        w_guard_nx = GUARD_LOAD;
                    end
                end
            end
            ST_GUARD: begin
                // Withdrawing oe during the guard aborts without driving.
                if (!core.core_data_oe)  w_state_nx = ST_IDLE;
                else if (r_guard == 2'd0) w_state_nx = ST_DRIVE;
                else                      w_guard_nx = r_guard - 2'd1;
            end
            ST_DRIVE: begin
                if (!core.core_data_oe) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_guard  <= 2'd0;
            r_oe_q   <= 1'b0;
            r_data_q <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_guard  <= w_guard_nx;
            // Registered enable keeps the pad oe glitch-free.
            r_oe_q   <= (w_state_nx == ST_DRIVE);
            r_data_q <= core.core_data_o;
        end
    end

    // Pad mapping: open-drain pulls low only for zero bits.
    if (OPEN_DRAIN) begin : g_open_drain
        assign pad_data_out = '0;
        assign pad_data_oe  = {DATA_W{r_oe_q}} & ~r_data_q;
    end else begin : g_push_pull
        assign pad_data_out = r_data_q;
        assign pad_data_oe  = {DATA_W{r_oe_q}};
    end

    // Input synchronisers
    mcs4_pad_bridge_sync_ff #(
        .W(DATA_W), .STAGES(SYNC_STAGES), .RST_VAL({DATA_W{DATA_IDLE_BIT}})
    ) u_sync_data (
        .clk(clk), .rst_n(rst_n), .i_d(pad_data_in), .o_q(core.core_data_i)
    );

    mcs4_pad_bridge_sync_ff #(
        .W(1), .STAGES(SYNC_STAGES), .RST_VAL(TEST_IDLE)
    ) u_sync_test (
        .clk(clk), .rst_n(rst_n), .i_d(pad_test), .o_q(core.core_test)
    );

    // Delay the driven value so it lines up with the synchronised readback.
    mcs4_pad_bridge_sync_ff #(
        .W(DATA_W + 1), .STAGES(SYNC_STAGES), .RST_VAL('0)
    ) u_dly (
        .clk(clk), .rst_n(rst_n), .i_d({r_oe_q, r_data_q}), .o_q({w_oe_dly, w_data_dly})
    );

    // The first aligned drive cycle is skipped: the pin may still be settling.
    assign w_contention_set = w_oe_dly & r_oe_dly_prev & (core.core_data_i != w_data_dly);

    // Sticky flags: a set condition beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oe_dly_prev <= 1'b0;
            r_sync_err    <= 1'b0;
            r_contention  <= 1'b0;
        end else begin
            r_oe_dly_prev <= w_oe_dly;
            r_sync_err    <= w_sync_err_set   | (r_sync_err   & ~err_clr);
            r_contention  <= w_contention_set | (r_contention & ~err_clr);
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_phase_valid;
    assign sync_err    = r_sync_err;
    assign contention  = r_contention;
endmodule

// File: tb/tb_mcs4_pad_bridge.sv
// Self-checking bench for mcs4_pad_bridge. Three instances share one
// stimulus stream:
//   u_a : open-drain, SYNC_STAGES=2, TURNAROUND=2
//   u_b : push-pull,  SYNC_STAGES=1, TURNAROUND=0
//   u_c : open-drain, SYNC_STAGES=3, TURNAROUND=1
// Each instance sees a pad model: driven bits take the pad output value,
// released bits float high; fault_en overrides the pins with fault_val.
module tb_mcs4_pad_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync_n, data_oe, cm_rom_n, err_clr, pad_test_i, fault_en;
    logic [3:0] data_o, cm_ram_n, fault_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcs4_pad_bridge_if #(.DATA_W(4), .NUM_CM_RAM(4)) if_a ();
    mcs4_pad_bridge_if #(.DATA_W(4), .NUM_CM_RAM(4)) if_b ();
    mcs4_pad_bridge_if #(.DATA_W(4), .NUM_CM_RAM(4)) if_c ();

    assign if_a.core_sync_n = sync_n;   assign if_b.core_sync_n = sync_n;   assign if_c.core_sync_n = sync_n;
    assign if_a.core_data_o = data_o;   assign if_b.core_data_o = data_o;   assign if_c.core_data_o = data_o;
    assign if_a.core_data_oe = data_oe; assign if_b.core_data_oe = data_oe; assign if_c.core_data_oe = data_oe;
    assign if_a.core_cm_rom_n = cm_rom_n; assign if_b.core_cm_rom_n = cm_rom_n; assign if_c.core_cm_rom_n = cm_rom_n;
    assign if_a.core_cm_ram_n = cm_ram_n; assign if_b.core_cm_ram_n = cm_ram_n; assign if_c.core_cm_ram_n = cm_ram_n;

    logic [3:0] pin_a, out_a, oe_a, ram_a;  logic sy_a, rom_a, pv_a, se_a, ct_a; logic [2:0] ph_a;
    logic [3:0] pin_b, out_b, oe_b, ram_b;  logic sy_b, rom_b, pv_b, se_b, ct_b; logic [2:0] ph_b;
    logic [3:0] pin_c, out_c, oe_c, ram_c;  logic sy_c, rom_c, pv_c, se_c, ct_c; logic [2:0] ph_c;

    assign pin_a = fault_en ? fault_val : ((out_a & oe_a) | ~oe_a);
    assign pin_b = fault_en ? fault_val : ((out_b & oe_b) | ~oe_b);
    assign pin_c = fault_en ? fault_val : ((out_c & oe_c) | ~oe_c);

    mcs4_pad_bridge #(.DATA_W(4), .NUM_CM_RAM(4), .OPEN_DRAIN(1'b1), .SYNC_STAGES(2), .TURNAROUND(2)) u_a (
        .clk(clk), .rst_n(rst_n), .core(if_a.slave), .pad_data_in(pin_a), .pad_data_out(out_a),
        .pad_data_oe(oe_a), .pad_test(pad_test_i), .pad_sync_n(sy_a), .pad_cm_rom_n(rom_a),
        .pad_cm_ram_n(ram_a), .phase(ph_a), .phase_valid(pv_a), .sync_err(se_a),
        .contention(ct_a), .err_clr(err_clr));

    mcs4_pad_bridge #(.DATA_W(4), .NUM_CM_RAM(4), .OPEN_DRAIN(1'b0), .SYNC_STAGES(1), .TURNAROUND(0)) u_b (
        .clk(clk), .rst_n(rst_n), .core(if_b.slave), .pad_data_in(pin_b), .pad_data_out(out_b),
        .pad_data_oe(oe_b), .pad_test(pad_test_i), .pad_sync_n(sy_b), .pad_cm_rom_n(rom_b),
        .pad_cm_ram_n(ram_b), .phase(ph_b), .phase_valid(pv_b), .sync_err(se_b),
        .contention(ct_b), .err_clr(err_clr));

    mcs4_pad_bridge #(.DATA_W(4), .NUM_CM_RAM(4), .OPEN_DRAIN(1'b1), .SYNC_STAGES(3), .TURNAROUND(1)) u_c (
        .clk(clk), .rst_n(rst_n), .core(if_c.slave), .pad_data_in(pin_c), .pad_data_out(out_c),
        .pad_data_oe(oe_c), .pad_test(pad_test_i), .pad_sync_n(sy_c), .pad_cm_rom_n(rom_c),
        .pad_cm_ram_n(ram_c), .phase(ph_c), .phase_valid(pv_c), .sync_err(se_c),
        .contention(ct_c), .err_clr(err_clr));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic       cm_rom_n;
        logic [3:0] cm_ram_n;
        logic [3:0] data_o;
        logic [3:0] exp_oe_od;   // open-drain enables: ~data
        logic [3:0] exp_out_pp;  // push-pull pin value
    } vec_t;

    vec_t vecs[6];

    initial begin
        int first_a, first_b, first_c, n, any_drive;

        vecs[0] = '{1'b1, 4'hE, 4'hA, 4'h5, 4'hA};
        vecs[1] = '{1'b0, 4'hD, 4'h5, 4'hA, 4'h5};
        vecs[2] = '{1'b1, 4'hB, 4'h0, 4'hF, 4'h0};
        vecs[3] = '{1'b0, 4'h7, 4'hF, 4'h0, 4'hF};
        vecs[4] = '{1'b1, 4'h0, 4'h3, 4'hC, 4'h3};
        vecs[5] = '{1'b1, 4'hF, 4'hA, 4'h5, 4'hA};

        rst_n = 1'b0; sync_n = 1'b1; data_oe = 1'b0; data_o = 4'h0;
        cm_rom_n = 1'b1; cm_ram_n = 4'hF; err_clr = 1'b0; pad_test_i = 1'b0;
        fault_en = 1'b0; fault_val = 4'h0;
        step(3);

        // Reset state
        check("rst_sync_n", sy_a, 1);
        check("rst_cm_rom_n", rom_a, 1);
        check("rst_cm_ram_n", ram_a, 4'hF);
        check("rst_data_oe", oe_a, 0);
        check("rst_data_out", out_a, 0);
        check("rst_core_data_i", if_a.core_data_i, 4'hF);
        check("rst_core_test", if_a.core_test, 0);
        check("rst_phase", ph_a, 0);
        check("rst_phase_valid", pv_a, 0);
        check("rst_sync_err", se_a, 0);
        check("rst_contention", ct_a, 0);
        check("rst_pp_data_out", out_b, 0);

        rst_n = 1'b1;
        step(3);
        check("phase_valid_before_sync", pv_a, 0);

        // Regular SYNC every 8 clocks
        sync_n = 1'b0;
        step();
        sync_n = 1'b1;
        check("phase_after_sync", ph_a, 0);
        check("phase_valid_after_sync", pv_a, 1);
        check("pad_sync_n_low", sy_a, 0);
        for (int k = 1; k < 8; k++) begin
            step();
            check("phase_seq", ph_a, k);
        end
        sync_n = 1'b0;
        step();
        sync_n = 1'b1;
        check("phase_wrap_sync", ph_a, 0);
        check("sync_err_on_time", se_a, 0);

        // Early SYNC at phase 4
        step(4);
        check("phase_before_early", ph_a, 4);
        sync_n = 1'b0;
        step();
        sync_n = 1'b1;
        check("phase_after_early", ph_a, 0);
        check("sync_err_early", se_a, 1);
        check("sync_err_early_b", se_b, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("sync_err_cleared", se_a, 0);

        // Turnaround latency: first drive 1+TURNAROUND edges after oe rises
        data_o = 4'hA;
        data_oe = 1'b1;
        first_a = 0; first_b = 0; first_c = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (first_a == 0 && oe_a != 4'h0) first_a = k;
            if (first_b == 0 && oe_b != 4'h0) first_b = k;
            if (first_c == 0 && oe_c != 4'h0) first_c = k;
        end
        check("turnaround_lat_a", first_a, 3);
        check("turnaround_lat_b", first_b, 1);
        check("turnaround_lat_c", first_c, 2);
        check("od_oe_1010", oe_a, 4'h5);
        check("od_out_1010", out_a, 4'h0);
        check("pp_oe_1010", oe_b, 4'hF);
        check("pp_out_1010", out_b, 4'hA);

        // Table: control pins and drive mapping while driving
        for (int i = 0; i < 6; i++) begin
            cm_rom_n = vecs[i].cm_rom_n;
            cm_ram_n = vecs[i].cm_ram_n;
            data_o   = vecs[i].data_o;
            step();
            check("vec_cm_rom_n", rom_a, vecs[i].cm_rom_n);
            check("vec_cm_ram_n", ram_a, vecs[i].cm_ram_n);
            check("vec_od_oe", oe_a, vecs[i].exp_oe_od);
            check("vec_od_oe_c", oe_c, vecs[i].exp_oe_od);
            check("vec_od_out", out_a, 4'h0);
            check("vec_pp_oe", oe_b, 4'hF);
            check("vec_pp_out", out_b, vecs[i].exp_out_pp);
        end
        step(4);
        check("no_contention_a", ct_a, 0);
        check("no_contention_b", ct_b, 0);
        check("no_contention_c", ct_c, 0);

        // Release drops the drive on the next edge
        data_oe = 1'b0;
        step();
        check("release_oe_a", oe_a, 0);
        check("release_oe_b", oe_b, 0);

        // Two-cycle oe pulse never reaches the pad with TURNAROUND=2
        data_o = 4'hA;
        any_drive = 0;
        data_oe = 1'b1;
        step();
        if (oe_a != 4'h0) any_drive = 1;
        step();
        if (oe_a != 4'h0) any_drive = 1;
        data_oe = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (oe_a != 4'h0) any_drive = 1;
        end
        check("short_pulse_no_drive", any_drive, 0);

        // Contention: drive A while the pins read 2
        fault_val = 4'h2;
        fault_en = 1'b1;
        data_oe = 1'b1;
        n = 0;
        while (oe_a == 4'h0 && n < 10) begin
            step();
            n++;
        end
        check("cont_drive_started", oe_a, 4'h5);
        step(3);
        check("cont_not_yet", ct_a, 0);
        step();
        check("cont_set", ct_a, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("cont_clr_while_fault", ct_a, 1);
        fault_en = 1'b0;
        step(4);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("cont_cleared", ct_a, 0);
        step(2);
        check("cont_stays_clear", ct_a, 0);
        data_oe = 1'b0;
        step(2);

        // Input synchroniser depth on TEST
        pad_test_i = 1'b1;
        first_a = 0; first_b = 0; first_c = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (first_a == 0 && if_a.core_test) first_a = k;
            if (first_b == 0 && if_b.core_test) first_b = k;
            if (first_c == 0 && if_c.core_test) first_c = k;
        end
        check("test_rise_ss2", first_a, 2);
        check("test_rise_ss1", first_b, 1);
        check("test_rise_ss3", first_c, 3);
        pad_test_i = 1'b0;
        first_a = 0; first_b = 0; first_c = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (first_a == 0 && !if_a.core_test) first_a = k;
            if (first_b == 0 && !if_b.core_test) first_b = k;
            if (first_c == 0 && !if_c.core_test) first_c = k;
        end
        check("test_fall_ss2", first_a, 2);
        check("test_fall_ss1", first_b, 1);
        check("test_fall_ss3", first_c, 3);

        // Asynchronous reset in the middle of a drive
        data_o = 4'hA;
        cm_rom_n = 1'b0;
        cm_ram_n = 4'h0;
        data_oe = 1'b1;
        step(5);
        check("pre_reset_driving", oe_a, 4'h5);
        check("pre_reset_rom_low", rom_a, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_oe_a", oe_a, 0);
        check("mid_rst_oe_b", oe_b, 0);
        check("mid_rst_rom_n", rom_a, 1);
        check("mid_rst_ram_n", ram_a, 4'hF);
        check("mid_rst_sync_n", sy_a, 1);
        check("mid_rst_core_data_i", if_a.core_data_i, 4'hF);
        check("mid_rst_phase_valid", pv_a, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
